// File: rtl/dpram_pkg.sv
// Shared types and helpers for the single-clock true dual-port RAM.
package dpram_pkg;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    // Upper bounds for the generic byte-merge helper; callers zero-extend and truncate.
    localparam int unsigned MERGE_MAX_W  = 256;
    localparam int unsigned MERGE_MAX_NB = 32;
    localparam int unsigned LANE_IW      = $clog2(MERGE_MAX_NB);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } init_state_e;

    function automatic int unsigned lane_count(input int unsigned width, input int unsigned byte_w);
        return width / byte_w;
    endfunction

    // Replace the lanes of old_w selected by be with the matching lanes of new_w.
    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0]  old_w,
        input logic [MERGE_MAX_W-1:0]  new_w,
        input logic [MERGE_MAX_NB-1:0] be,
        input int unsigned             byte_w
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_w;
        for (int unsigned j = 0; j < MERGE_MAX_W; j++) begin
            if ((j / byte_w) < MERGE_MAX_NB) begin
                if (be[LANE_IW'(j / byte_w)]) begin
                    res[j] = new_w[j];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tdpram_sclk_be_if.sv
// One RAM access port: request, byte enables, write data and registered read return.
interface tdpram_sclk_be_if
    import dpram_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ADDRESS = 6,
    parameter int unsigned BYTE_W  = 8
) ();

    localparam int unsigned NB = lane_count(WIDTH, BYTE_W);

    logic               en;
    logic               wr_en;
    logic [NB-1:0]      be;
    logic [ADDRESS-1:0] addr;
    logic [WIDTH-1:0]   data_in;
    logic [WIDTH-1:0]   data_out;
    logic               rd_valid;

    modport master (
        output en, wr_en, be, addr, data_in,
        input  data_out, rd_valid
    );

    modport slave (
        input  en, wr_en, be, addr, data_in,
        output data_out, rd_valid
    );

endinterface

// File: rtl/dpram_init_ctrl.sv
// Post-reset clear sweep: walks every word once, then hands the array to the ports.
module dpram_init_ctrl
    import dpram_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned ADDRESS = 6
) (
    input  logic               clk,
    input  logic               rst,
    output logic               init_busy,
    output logic               clr_we_c,
    output logic [ADDRESS-1:0] clr_addr_c
);

    init_state_e        state;
    logic [ADDRESS-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            cnt       <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + ADDRESS'(1);
                    if (cnt == ADDRESS'(DEPTH - 1)) begin
                        state     <= READY;
                        init_busy <= 1'b0;
                    end
                end
                READY:   state <= READY;
                default: state <= CLEAR;
            endcase
        end
    end

    assign clr_we_c   = (state == CLEAR);
    assign clr_addr_c = cnt;

endmodule

// File: rtl/tdpram_sclk_be.sv
// Single-clock true dual-port RAM with byte enables and deterministic collisions.
// Define DPRAM_OUTREG_EN to add one output register stage per port (read latency 2).
module tdpram_sclk_be
    import dpram_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned ADDRESS  = 6,
    parameter int unsigned BYTE_W   = 8,
    parameter int unsigned RDW_MODE = RDW_OLD
) (
    input  logic             clk,
    input  logic             rst,
    output logic             init_busy,
    tdpram_sclk_be_if.slave  port_A,
    tdpram_sclk_be_if.slave  port_B,
    output logic             collision
);

    localparam int unsigned NB  = lane_count(WIDTH, BYTE_W);
    localparam int unsigned MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AW1 = ADDRESS + 1;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic               clr_we_c;
    logic [ADDRESS-1:0] clr_addr_c;

    dpram_init_ctrl #(
        .DEPTH   (DEPTH),
        .ADDRESS (ADDRESS)
    ) u_init_ctrl (
        .clk        (clk),
        .rst        (rst),
        .init_busy  (init_busy),
        .clr_we_c   (clr_we_c),
        .clr_addr_c (clr_addr_c)
    );

    function automatic logic [WIDTH-1:0] merge_word(
        input logic [WIDTH-1:0] old_w,
        input logic [WIDTH-1:0] new_w,
        input logic [NB-1:0]    be
    );
        return WIDTH'(byte_merge(MERGE_MAX_W'(old_w), MERGE_MAX_W'(new_w),
                                 MERGE_MAX_NB'(be), BYTE_W));
    endfunction

    logic             in_a_c, in_b_c, acc_a_c, acc_b_c, wr_a_c, wr_b_c, same_c, col_c;
    logic [MW-1:0]    idx_a_c, idx_b_c;
    logic [WIDTH-1:0] old_a_c, old_b_c, merged_b_c, new_a_c, new_b_c, rd_a_c, rd_b_c;

    // Request qualification and read-during-write data; on a shared write A lands on top of B.
    always_comb begin
        in_a_c     = {1'b0, port_A.addr} < AW1'(DEPTH);
        in_b_c     = {1'b0, port_B.addr} < AW1'(DEPTH);
        acc_a_c    = !rst && !init_busy && port_A.en;
        acc_b_c    = !rst && !init_busy && port_B.en;
        wr_a_c     = acc_a_c && port_A.wr_en && (|port_A.be) && in_a_c;
        wr_b_c     = acc_b_c && port_B.wr_en && (|port_B.be) && in_b_c;
        idx_a_c    = MW'(port_A.addr);
        idx_b_c    = MW'(port_B.addr);
        old_a_c    = mem[idx_a_c];
        old_b_c    = mem[idx_b_c];
        same_c     = (port_A.addr == port_B.addr) && in_a_c;
        col_c      = acc_a_c && acc_b_c && same_c && (wr_a_c || wr_b_c);
        merged_b_c = merge_word(old_b_c, port_B.data_in, port_B.be);
        new_a_c    = merge_word((wr_b_c && same_c) ? merged_b_c : old_a_c,
                                port_A.data_in, port_A.be);
        new_b_c    = (wr_a_c && same_c) ? new_a_c : merged_b_c;
        rd_a_c     = !in_a_c ? '0 :
                     ((RDW_MODE == RDW_NEW) && wr_a_c) ? new_a_c : old_a_c;
        rd_b_c     = !in_b_c ? '0 :
                     ((RDW_MODE == RDW_NEW) && wr_b_c) ? new_b_c : old_b_c;
    end

    // Array writes: sweep zeroes while busy, otherwise per-lane port writes (A issued last, so A wins).
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[MW'(clr_addr_c)] <= '0;
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_b_c && port_B.be[i]) begin
                    mem[idx_b_c][i*BYTE_W +: BYTE_W] <= port_B.data_in[i*BYTE_W +: BYTE_W];
                end
                if (wr_a_c && port_A.be[i]) begin
                    mem[idx_a_c][i*BYTE_W +: BYTE_W] <= port_A.data_in[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    logic [WIDTH-1:0] dout_a_q, dout_b_q;
    logic             vld_a_q, vld_b_q, col_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_a_q <= '0;
            dout_b_q <= '0;
            vld_a_q  <= 1'b0;
            vld_b_q  <= 1'b0;
            col_q    <= 1'b0;
        end else begin
            vld_a_q <= acc_a_c;
            vld_b_q <= acc_b_c;
            col_q   <= col_c;
            if (acc_a_c) dout_a_q <= rd_a_c;
            if (acc_b_c) dout_b_q <= rd_b_c;
        end
    end

`ifdef DPRAM_OUTREG_EN
    logic [WIDTH-1:0] dout_a_q2, dout_b_q2;
    logic             vld_a_q2, vld_b_q2, col_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_a_q2 <= '0;
            dout_b_q2 <= '0;
            vld_a_q2  <= 1'b0;
            vld_b_q2  <= 1'b0;
            col_q2    <= 1'b0;
        end else begin
            dout_a_q2 <= dout_a_q;
            dout_b_q2 <= dout_b_q;
            vld_a_q2  <= vld_a_q;
            vld_b_q2  <= vld_b_q;
            col_q2    <= col_q;
        end
    end

    assign port_A.data_out = dout_a_q2;
    assign port_B.data_out = dout_b_q2;
    assign port_A.rd_valid = vld_a_q2;
    assign port_B.rd_valid = vld_b_q2;
    assign collision       = col_q2;
`else
    assign port_A.data_out = dout_a_q;
    assign port_B.data_out = dout_b_q;
    assign port_A.rd_valid = vld_a_q;
    assign port_B.rd_valid = vld_b_q;
    assign collision       = col_q;
`endif

endmodule

// File: doc/tdpram_sclk_be.md
Name: tdpram_sclk_be

Overview:
Single-clock true dual-port RAM with per-byte write enables, a selectable read-during-write mode, defined cross-port collision arbitration, read-valid strobes and a hardware clear-on-reset sweep. It generalises the team's dual-port RAM to wide words and adds deterministic behaviour for every port collision. It sits beside the team's other RAM blocks as the shared buffer for two masters in one clock domain.

Parameters:
WIDTH, 8, data word width in bits; must be a multiple of BYTE_W.
DEPTH, 64, number of words; DEPTH <= 2**ADDRESS.
ADDRESS, 6, address width in bits.
BYTE_W, 8, bits per byte lane; lane count NB = WIDTH/BYTE_W.
RDW_MODE, 0, same-port read-during-write result: 0 = old data, 1 = new merged data.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
init_busy  out  1  clear sweep in progress; port requests ignored while high.
en_A  in  1  port A request.
wr_en_A  in  1  port A write (valid only with en_A).
be_A  in  NB  port A byte-lane write enables.
addr_A  in  ADDRESS  port A address.
data_in_A  in  WIDTH  port A write data.
data_out_A  out  WIDTH  port A read data.
rd_valid_A  out  1  data_out_A updated this cycle.
en_B, wr_en_B, be_B, addr_B, data_in_B, data_out_B, rd_valid_B: same as port A, for port B.
collision  out  1  one-cycle pulse flagging a same-address conflict.

Behaviour:
- Reset (rst high at an edge): data_out_A/B = 0, rd_valid_A/B = 0, collision = 0, init_busy = 1, sweep counter = 0.
- FSM has two states, CLEAR and READY. Reset forces CLEAR.
- CLEAR: writes 0 to ram[cnt] each cycle and increments cnt. After writing DEPTH-1 it moves to READY; init_busy drops on that same edge. The sweep therefore takes exactly DEPTH cycles after rst deasserts.
- During CLEAR, port writes are dropped and rd_valid stays 0. If rst is asserted mid-sweep, the counter restarts at 0.
- READY, port access: a request with en is accepted at edge N. data_out and rd_valid are valid after edge N (latency 1). rd_valid pulses for every accepted request, read or write.
- data_out holds its last value when the port is idle.
- Writes update only lanes whose be bit = 1. A write with be = 0 acts as a read.
- Same-port read-during-write: RDW_MODE=0 returns the pre-write word. RDW_MODE=1 returns the word after the byte merge.
- Out of range (addr >= DEPTH): the write is dropped, data_out = 0, rd_valid = 1.
- Collision is both ports enabled, equal in-range addresses, and at least one port writing. The collision output pulses 1 on the next cycle.
  - Write-write: in lanes where both be bits are set, port A wins. A lane with only one be bit set takes that port's data.
  - Read vs write: the reading port always gets the old word, whatever RDW_MODE is. The writing port follows RDW_MODE.
  - Read-read at the same address does not raise collision.

Optional Feature:
DPRAM_OUTREG_EN:
- Defined: adds one output register stage per port. Read latency becomes 2, and rd_valid and collision are delayed by the same cycle. Reset clears the extra stage to 0.
- Undefined: latency 1, as described above.

Decomposition:
- Package dpram_pkg holds:
  - RDW_OLD = 0 and RDW_NEW = 1 constants;
  - FSM state typedef {CLEAR, READY};
  - a lane-count function WIDTH/BYTE_W;
  - a byte-merge function (old, new, be).
- Sub-module dpram_init_ctrl holds the sweep FSM, counter, init_busy and the clear write address/enable. The RAM array and port logic stay in the top.

Test Plan:
1. rst high for 1 cycle, then low -> init_busy = 1 for exactly 64 cycles. Reading addresses 0..63 then returns 0x00 with rd_valid = 1.
2. A writes 0xA5 @3 (be = 1); next cycle B reads @3 -> data_out_B = 0xA5 one cycle later, rd_valid_B = 1, collision = 0.
3. WIDTH=32: write 0x11223344 @5 (be = 4'hF), then 0xFFFFFFFF @5 with be = 4'b0010, then read @5 -> 0x1122FF44.
4. Same cycle @9: A writes 0x11 and B writes 0x22, both be = 1 -> collision = 1 for one cycle; a later read @9 returns 0x11.
5. @7 holds 0x00. A writes 0x5A while B reads @7 -> data_out_B = 0x00 and collision = 1. data_out_A = 0x00 with RDW_MODE=0, or 0x5A with RDW_MODE=1.
6. rst asserted at sweep count 20 -> sweep restarts from 0 and init_busy stays high 64 more cycles. A write request during the sweep is dropped (memory reads 0x00 later) and rd_valid stays 0.
